// File: rtl/axi4_stream_pkt_if.sv
// AXI4-Stream bundle shared by the packet framer and its neighbours.
// Modport d is the receiving side of a stream, modport s the driving side.
interface axi4_stream_if #(
    parameter int DN = 1
) (
    input logic ACLK,
    input logic ARESETn
);
    logic              TVALID;
    logic              TREADY;
    logic [8*DN-1:0]   TDATA;
    logic [DN-1:0]     TKEEP;
    logic              TLAST;

    modport d (
        input  ACLK,
        input  ARESETn,
        input  TVALID,
        input  TDATA,
        input  TKEEP,
        input  TLAST,
        output TREADY
    );

    modport s (
        output TVALID,
        output TDATA,
        output TKEEP,
        output TLAST,
        input  TREADY
    );
endinterface

// File: rtl/axi4_stream_pkt.sv
// AXI4-Stream packet framer: zero-latency pass-through that inserts TLAST every
// cfg_len+1 transfers under start/stop control; stops always finish the packet.
module axi4_stream_pkt #(
    parameter int DN = 1,
    parameter int CW = 16
) (
    axi4_stream_if.d      sti,
    axi4_stream_if.s      sto,
    input  logic          ctl_start,
    input  logic          ctl_stop,
    input  logic [CW-1:0] cfg_len,
    output logic          sts_run,
    output logic [CW-1:0] sts_pkt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   len_r;
    logic [CW-1:0]   pkt_r;
    logic            run_r;
    logic            active_s;
    logic            at_last_s;
    logic            xfer_s;
    logic            last_xfer_s;
    logic            start_s;
    logic [8*DN-1:0] data_s;
    logic [DN-1:0]   keep_s;
    logic            unused_tlast_s;

    assign active_s    = (state_r != IDLE);
    assign at_last_s   = (cnt_r == len_r);
    assign xfer_s      = active_s & sti.TVALID & sto.TREADY;
    assign last_xfer_s = xfer_s & at_last_s;
    assign start_s     = (state_r == IDLE) & ctl_start & ~ctl_stop;

    // Upstream framing is replaced by our own count, so the incoming TLAST is dropped.
    assign unused_tlast_s = sti.TLAST;
    assign data_s         = sti.TDATA;
    assign keep_s         = sti.TKEEP;

    assign sto.TVALID = active_s & sti.TVALID;
    assign sti.TREADY = active_s & sto.TREADY;
    assign sto.TDATA  = data_s;
    assign sto.TKEEP  = keep_s;
    assign sto.TLAST  = active_s & at_last_s;

    assign sts_run = run_r;
    assign sts_pkt = pkt_r;

    // Next-state decode; a stop in RUN only short-cuts to IDLE on a packet boundary.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (ctl_stop) begin
                    if (last_xfer_s || ((cnt_r == ZERO) && !xfer_s)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = STOP;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            STOP: begin
                if (last_xfer_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and the registered run flag derived from the next state.
    always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
        if (!sti.ARESETn) begin
            state_r <= IDLE;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            run_r   <= (state_s != IDLE);
        end
    end

    // Beat counter, latched length (reloaded only at packet boundaries) and packet count.
    always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
        if (!sti.ARESETn) begin
            cnt_r <= ZERO;
            len_r <= ZERO;
            pkt_r <= ZERO;
        end else if (start_s) begin
            cnt_r <= ZERO;
            len_r <= cfg_len;
        end else if (last_xfer_s) begin
            cnt_r <= ZERO;
            len_r <= cfg_len;
            pkt_r <= pkt_r + ONE;
        end else if (xfer_s) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: tb/tb_axi4_stream_pkt.sv
// Self-checking bench for axi4_stream_pkt: table-driven runs, hand-written stop/reset
// sequences and randomized handshakes, all checked every cycle against a reference model.
module tb_axi4_stream_pkt;
    localparam int DN = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] cfg = '0;
    logic          sts_run;
    logic [CW-1:0] sts_pkt;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer = 0;
    bit obs_last[$];

    // Reference model: framing on/off, stop pending, position in packet, latched length.
    bit m_on = 1'b0;
    bit m_drain = 1'b0;
    int m_pos = 0;
    int m_len = 0;
    int m_pkts = 0;

    typedef struct {
        int len;
        int beats;
        int pkts;
        int lasts;
        bit run_after;
    } row_t;
    row_t tbl[5];

    always #5 clk = ~clk;

    axi4_stream_if #(.DN(DN)) sti_if (.ACLK(clk), .ARESETn(rst_n));
    axi4_stream_if #(.DN(DN)) sto_if (.ACLK(clk), .ARESETn(rst_n));

    axi4_stream_pkt #(.DN(DN), .CW(CW)) dut (
        .sti       (sti_if),
        .sto       (sto_if),
        .ctl_start (start),
        .ctl_stop  (stop),
        .cfg_len   (cfg),
        .sts_run   (sts_run),
        .sts_pkt   (sts_pkt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle comparison of every output against the model, then advance the model.
    task automatic mon();
        bit x;
        bit l;
        bit p0;
        if (!rst_n) begin
            m_on = 1'b0; m_drain = 1'b0; m_pos = 0; m_len = 0; m_pkts = 0;
        end
        chk("sts_run", sts_run, m_on);
        chk("sts_pkt", sts_pkt, m_pkts);
        chk("sto_tvalid", sto_if.TVALID, m_on & sti_if.TVALID);
        chk("sti_tready", sti_if.TREADY, m_on & sto_if.TREADY);
        if (m_on) begin
            chk("tdata", sto_if.TDATA, sti_if.TDATA);
            chk("tkeep", sto_if.TKEEP, sti_if.TKEEP);
            chk("tlast", sto_if.TLAST, (m_pos == m_len));
        end
        if (sto_if.TVALID && sto_if.TREADY) begin
            obs_last.push_back(sto_if.TLAST);
            n_xfer++;
        end
        if (rst_n) begin
            if (!m_on) begin
                if (start && !stop) begin
                    m_on = 1'b1; m_drain = 1'b0; m_pos = 0; m_len = int'(cfg);
                end
            end else begin
                x  = sti_if.TVALID & sto_if.TREADY;
                l  = x && (m_pos == m_len);
                p0 = (m_pos == 0);
                if (l) begin
                    m_pos = 0; m_len = int'(cfg); m_pkts = (m_pkts + 1) % (1 << CW);
                end else if (x) begin
                    m_pos++;
                end
                if (m_drain) begin
                    if (l) begin m_on = 1'b0; m_drain = 1'b0; end
                end else if (stop) begin
                    if (l || (p0 && !x)) m_on = 1'b0;
                    else m_drain = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        obs_last.delete();
        n_xfer = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        clear();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_beats(input int n);
        int g;
        int base;
        base = n_xfer;
        g = 0;
        sti_if.TVALID = 1'b1;
        sto_if.TREADY = 1'b1;
        while ((n_xfer - base) < n && g < n * 4 + 20) begin
            sti_if.TDATA = 16'($urandom);
            sti_if.TKEEP = 2'($urandom);
            cyc();
            g++;
        end
        sti_if.TVALID = 1'b0;
        chk("beats_done", n_xfer - base, n);
    endtask

    function automatic int count_lasts();
        int c = 0;
        foreach (obs_last[i]) if (obs_last[i]) c++;
        return c;
    endfunction

    initial begin
        logic [6:0] pat;
        int g;

        tbl[0] = '{len: 3,   beats: 12,  pkts: 3, lasts: 3, run_after: 1'b0};
        tbl[1] = '{len: 0,   beats: 5,   pkts: 5, lasts: 5, run_after: 1'b0};
        tbl[2] = '{len: 1,   beats: 6,   pkts: 3, lasts: 3, run_after: 1'b0};
        tbl[3] = '{len: 4,   beats: 7,   pkts: 1, lasts: 1, run_after: 1'b1};
        tbl[4] = '{len: 255, beats: 257, pkts: 1, lasts: 1, run_after: 1'b1};

        sti_if.TVALID = 1'b0;
        sti_if.TDATA  = '0;
        sti_if.TKEEP  = '0;
        sti_if.TLAST  = 1'b0;
        sto_if.TREADY = 1'b0;
        #2;
        chk("reset_run", sts_run, 1'b0);
        chk("reset_pkt", sts_pkt, 8'd0);
        do_reset();

        // Table-driven continuous runs with a stop pulse at the end.
        for (int r = 0; r < 5; r++) begin
            do_reset();
            cfg = CW'(tbl[r].len);
            pulse_start();
            run_beats(tbl[r].beats);
            chk("row_run_mid", sts_run, 1'b1);
            stop = 1'b1;
            cyc();
            stop = 1'b0;
            cyc();
            chk("row_lasts", count_lasts(), tbl[r].lasts);
            chk("row_pkts", sts_pkt, tbl[r].pkts);
            chk("row_run_end", sts_run, tbl[r].run_after);
        end
        chk("max_len_last_at_256", obs_last[255], 1'b1);
        chk("max_len_wrap_257", obs_last[256], 1'b0);

        // Stop after beat 2 of a 4-beat packet drains to beat 4.
        do_reset();
        cfg = 8'd3;
        pulse_start();
        run_beats(2);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_pending_run", sts_run, 1'b1);
        run_beats(2);
        sto_if.TREADY = 1'b1;
        #1;
        chk("stop_idle_run", sts_run, 1'b0);
        chk("stop_idle_tready", sti_if.TREADY, 1'b0);
        sti_if.TVALID = 1'b1;
        cyc();
        cyc();
        sti_if.TVALID = 1'b0;
        chk("stop_no_extra", n_xfer, 4);
        chk("stop_tlast_b3", obs_last[2], 1'b0);
        chk("stop_tlast_b4", obs_last[3], 1'b1);

        // Stop coinciding with a last transfer.
        do_reset();
        cfg = 8'd1;
        pulse_start();
        run_beats(1);
        sti_if.TVALID = 1'b1;
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_last_run", sts_run, 1'b0);
        chk("stop_last_pkt", sts_pkt, 8'd1);
        cyc();
        sti_if.TVALID = 1'b0;
        chk("stop_last_no_extra", n_xfer, 2);

        // Stop at a packet boundary with no transfer, then start+stop together in IDLE.
        pulse_start();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_cnt0_run", sts_run, 1'b0);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_idle", sts_run, 1'b0);
        cyc();
        chk("start_stop_idle2", sts_run, 1'b0);

        // Length change mid-packet takes effect only at the boundary.
        do_reset();
        cfg = 8'd3;
        pulse_start();
        run_beats(2);
        cfg = 8'd0;
        run_beats(5);
        pat = 7'b1111000;
        for (int i = 0; i < 7; i++) chk("len_change_tlast", obs_last[i], pat[i]);

        // Asynchronous reset in the middle of a cycle and of a packet.
        do_reset();
        cfg = 8'd1;
        pulse_start();
        run_beats(3);
        sti_if.TVALID = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", sto_if.TVALID, 1'b0);
        chk("arst_run", sts_run, 1'b0);
        chk("arst_pkt", sts_pkt, 8'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("arst_no_restart", n_xfer, 3);
        clear();
        cfg = 8'd2;
        pulse_start();
        run_beats(3);
        chk("arst_first_b1", obs_last[0], 1'b0);
        chk("arst_first_b2", obs_last[1], 1'b0);
        chk("arst_first_b3", obs_last[2], 1'b1);

        // Randomized handshakes: nothing while idle, TLAST on every 4th transfer.
        do_reset();
        cfg = 8'd3;
        for (int i = 0; i < 6; i++) begin
            sti_if.TVALID = 1'($urandom_range(0, 1));
            sto_if.TREADY = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("rand_idle_pre", n_xfer, 0);
        sti_if.TVALID = 1'b0;
        pulse_start();
        g = 0;
        while (n_xfer < 40 && g < 2000) begin
            sti_if.TVALID = 1'($urandom_range(0, 1));
            sto_if.TREADY = 1'($urandom_range(0, 1));
            sti_if.TDATA  = 16'($urandom);
            sti_if.TKEEP  = 2'($urandom);
            sti_if.TLAST  = 1'($urandom);
            cyc();
            g++;
        end
        sti_if.TVALID = 1'b0;
        chk("rand_count", n_xfer, 40);
        for (int i = 0; i < 40 && i < obs_last.size(); i++)
            chk("rand_tlast", obs_last[i], ((i % 4) == 3));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sti_if.TVALID = 1'($urandom_range(0, 1));
            sto_if.TREADY = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("rand_idle_post", n_xfer, 40);
        chk("rand_pkts", sts_pkt, 8'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi4_stream_pkt.md
# axi4_stream_pkt

Packet framer on an AXI4-Stream path, placed directly upstream of a stream pipeline register. Passes data through unchanged under software start/stop control, counts transfers and generates TLAST every `cfg_len+1` transfers. The counters and control FSM are registered. The data path is combinational pass-through, and the downstream register breaks the timing path. Stop requests always complete the current packet, so downstream never sees a truncated frame.

## Interface
Parameters:
- `DN`, 1: number of data bytes, passed to the stream interfaces; TDATA is `8*DN` bits wide, TKEEP is `DN` bits wide.
- `CW`, 16: width of the length register and both counters.

Ports:
- `sti.ACLK`  in  1  clock, the single clock domain; everything is rising-edge.
- `sti.ARESETn`  in  1  reset, asynchronous, active-low.
- `sti`  axi4_stream_if.d  —  input stream (TVALID, TREADY, TDATA, TKEEP, TLAST).
- `sto`  axi4_stream_if.s  —  output stream, same signal set as `sti`.
- `ctl_start`  in  1  single-cycle pulse: begin framing.
- `ctl_stop`  in  1  single-cycle pulse: finish the current packet, then go idle.
- `cfg_len`  in  CW  packet length minus one, in transfers.
- `sts_run`  out  1  high when the FSM is not IDLE.
- `sts_pkt`  out  CW  count of completed packets; wraps modulo 2^CW.

## Operation
- FSM states: IDLE, RUN, STOP.
  - IDLE:
    - `sti.TREADY=0` and `sto.TVALID=0`.
    - `ctl_start` with `ctl_stop` low moves to RUN.
    - On that start edge, `len_r<=cfg_len` and `cnt<=0`.
  - RUN / STOP data path:
    - `sto.TVALID=sti.TVALID`.
    - `sti.TREADY=sto.TREADY`.
    - TDATA and TKEEP pass through unchanged.
    - `sto.TLAST=(cnt==len_r)`; the input `sti.TLAST` is ignored.
  - Transfer definition: `sto.TVALID & sto.TREADY`.
  - On a non-last transfer: `cnt<=cnt+1`.
  - On a last transfer:
    - `cnt<=0`.
    - `len_r<=cfg_len`, so a new length takes effect only at a packet boundary.
    - `sts_pkt<=sts_pkt+1`.
- RUN transitions:
  - `ctl_stop` with `cnt==0` and no transfer in that cycle: go to IDLE.
  - `ctl_stop` in the same cycle as a last transfer: go to IDLE.
  - `ctl_stop` otherwise: go to STOP.
- STOP transitions:
  - A last transfer moves to IDLE.
  - `ctl_start` and `ctl_stop` are ignored.
- `ctl_start` in RUN or STOP is ignored; it never restarts `cnt`.
- `ctl_start` and `ctl_stop` together in IDLE: stop wins, the FSM stays IDLE.
- `cfg_len=0`: every transfer carries TLAST, giving single-beat packets.
- `cfg_len=2^CW-1`: packets of 2^CW beats; `cnt` reaches all-ones and wraps to 0 on TLAST.
- Reset, including mid-packet:
  - FSM goes to IDLE immediately and asynchronously.
  - `cnt=0`, `len_r=0`, `sts_pkt=0`, `sts_run=0`.
  - `sto.TVALID=0` and `sti.TREADY=0` immediately.
  - The partial packet is discarded with no TLAST; recovery requires a new `ctl_start`.

## Timing
- Start latency:
  - `ctl_start` sampled at edge n gives RUN from cycle n+1.
  - The first transfer is possible in cycle n+1.
  - `sts_run` goes high in cycle n+1.
- Data latency: zero cycles; TVALID, TREADY and data are combinational from `sti` to `sto` while RUN or STOP.
- TLAST is decoded from registered `cnt` and `len_r`, so it is stable for the whole cycle.
- End of run:
  - A last transfer at edge m with a stop pending gives IDLE and `sts_run=0` from cycle m+1.
  - No transfer is accepted after the final TLAST.
- `sts_pkt` updates one edge after the last transfer.
- Backpressure: `sto.TREADY` low holds `cnt` and the FSM state. `sto.TVALID` and TDATA follow `sti`, which is AXI-compliant as long as upstream holds its data while stalled.

## Test plan
- `cfg_len=3`, start, continuous valid/ready for 12 transfers -> TLAST on transfers 4, 8 and 12; `sts_pkt=3`; `sts_run=1`.
- `cfg_len=3`, random 50% TVALID and 50% TREADY over 40 transfers -> TLAST exactly on every 4th transfer; data and TKEEP bit-exact; no transfer while IDLE.
- Stop pulse after transfer 2 of a 4-beat packet -> STOP; beats 3 and 4 pass with TLAST on beat 4; IDLE one cycle later; `sti.TREADY=0` afterwards.
- Stop issued in the same cycle as a last transfer, and a separate stop issued at `cnt==0` -> IDLE on the next cycle in both cases, no extra beat; a simultaneous start+stop in IDLE keeps `sts_run=0`.
- `cfg_len` changed from 3 to 0 mid-packet -> the current packet still ends at beat 4, then every subsequent beat carries TLAST.
- Reset asserted asynchronously mid-cycle, mid-packet -> `sto.TVALID` and `sts_run` drop before the next edge; `sts_pkt=0`; after release plus a start pulse, the first TLAST appears at beat `cfg_len+1`.
